fp_div_sequencer: RTL and testbench

FP_DIV_SEQUENCER -- requirements
Module: fp_div_sequencer

---
 rtl/fp_div_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_fp_div_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fp_div_sequencer.sv
// Sequential floating-point divider: restoring mantissa division, one quotient bit per cycle,
// followed by a single normalize/pack cycle. Exponent 0 encodes zero; there are no denormals.
module fp_div_sequencer #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                start_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   b_in,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   result_out,
  output logic                                busy_out,
  output logic                                done_out,
  output logic                                underflow_out,
  output logic                                overflow_out,
  output logic                                div_by_zero_out
);

  localparam int unsigned W     = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int unsigned N     = MANTISSA_WIDTH + 2;
  localparam int unsigned EW2   = EXP_WIDTH + 2;
  localparam int unsigned BIAS  = (2 ** (EXP_WIDTH - 1)) - 1;
  localparam int unsigned EMAX  = (2 ** EXP_WIDTH) - 1;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DIVIDE    = 2'd1,
    S_NORMALIZE = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic                          pend_q, pend_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          sign_q, sign_d;
  logic                          a_zero_q, a_zero_d;
  logic                          b_zero_q, b_zero_d;
  logic [EW2-1:0]                e_q, e_d;
  logic [N-1:0]                  rem_q, rem_d;
  logic [N-1:0]                  div_q, div_d;
  logic [N-1:0]                  quo_q, quo_d;
  logic [W-1:0]                  result_q, result_d;
  logic                          uf_q, uf_d;
  logic                          of_q, of_d;
  logic                          dz_q, dz_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic                          qbit;
  logic [N-1:0]                  rem_sub;
  logic [EW2-1:0]                e_n;
  logic [MANTISSA_WIDTH-1:0]     frac;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    a_zero_d = a_zero_q;
    b_zero_d = b_zero_q;
    e_d      = e_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    result_d = result_q;
    uf_d     = uf_q;
    of_d     = of_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    qbit     = 1'b0;
    rem_sub  = rem_q;
    e_n      = e_q;
    frac     = '0;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          // Operands were latched on the previous edge; dispatch special or normal path.
          pend_d = 1'b0;
          if (b_zero_q) begin
            result_d = {sign_q, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
            dz_d     = 1'b1;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else if (a_zero_q) begin
            result_d = {sign_q, {(W-1){1'b0}}};
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d   = '0;
            state_d = S_DIVIDE;
          end
        end else if (start_in) begin
          pend_d   = 1'b1;
          sign_d   = a_in[W-1] ^ b_in[W-1];
          a_zero_d = (a_in[W-2:MANTISSA_WIDTH] == '0);
          b_zero_d = (b_in[W-2:MANTISSA_WIDTH] == '0);
          e_d      = EW2'(a_in[W-2:MANTISSA_WIDTH]) - EW2'(b_in[W-2:MANTISSA_WIDTH])
                     + EW2'(BIAS);
          rem_d    = {1'b0, 1'b1, a_in[MANTISSA_WIDTH-1:0]};
          div_d    = {1'b0, 1'b1, b_in[MANTISSA_WIDTH-1:0]};
          quo_d    = '0;
          uf_d     = 1'b0;
          of_d     = 1'b0;
          dz_d     = 1'b0;
        end
      end

      S_DIVIDE: begin
        if (rem_q >= div_q) begin
          qbit    = 1'b1;
          rem_sub = rem_q - div_q;
        end
        rem_d = rem_sub << 1;
        quo_d = {quo_q[N-2:0], qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_NORMALIZE;
        end
      end

      S_NORMALIZE: begin
        // Quotient lies in (0.5, 2): either keep the exponent or shift left by one.
        if (quo_q[N-1]) begin
          e_n  = e_q;
          frac = quo_q[N-2:1];
        end else begin
          e_n  = e_q - EW2'(1);
          frac = quo_q[N-3:0];
        end
        if (e_n[EW2-1] || (e_n == '0)) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          uf_d     = 1'b1;
        end else if (e_n >= EW2'(EMAX)) begin
          result_d = {sign_q, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
          of_d     = 1'b1;
        end else begin
          result_d = {sign_q, e_n[EXP_WIDTH-1:0], frac};
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      e_q      <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      a_zero_q <= a_zero_d;
      b_zero_q <= b_zero_d;
      e_q      <= e_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result_out      = result_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign underflow_out   = uf_q;
  assign overflow_out    = of_q;
  assign div_by_zero_out = dz_q;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Directed bench for fp_div_sequencer (single precision): latency, results, flags,
// ignored restart while busy, and mid-operation reset.
module tb_fp_div_sequencer;

  logic        clk_in;
  logic        rst_n_in;
  logic        start_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] result_out;
  logic        busy_out;
  logic        done_out;
  logic        underflow_out;
  logic        overflow_out;
  logic        div_by_zero_out;

  int n_checks = 0;
  int n_fail   = 0;

  fp_div_sequencer #(
    .EXP_WIDTH      (8),
    .MANTISSA_WIDTH (23)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .a_in            (a_in),
    .b_in            (b_in),
    .result_out      (result_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .underflow_out   (underflow_out),
    .overflow_out    (overflow_out),
    .div_by_zero_out (div_by_zero_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launch one division, watch a fixed window, optionally re-pulse start at cycle inject_at.
  // flags are packed {underflow, overflow, div_by_zero}.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [2:0] exp_flags,
                        input int exp_lat, input int inject_at);
    int          lat;
    int          n_done;
    logic        busy_ok;
    logic [31:0] res_at_done;
    logic [2:0]  flags_at_done;
    lat           = 0;
    n_done        = 0;
    busy_ok       = 1'b1;
    res_at_done   = 32'hDEAD_BEEF;
    flags_at_done = 3'b111;
    @(negedge clk_in);
    a_in     = a;
    b_in     = b;
    start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk_in);
      #1;
      if (c <= exp_lat && !busy_out) busy_ok = 1'b0;
      if (done_out) begin
        n_done++;
        if (lat == 0) begin
          lat           = c;
          res_at_done   = result_out;
          flags_at_done = {underflow_out, overflow_out, div_by_zero_out};
        end
      end
      if (c == inject_at) begin
        a_in     = 32'h3F80_0000;
        b_in     = 32'h4040_0000;
        start_in = 1'b1;
      end else begin
        start_in = 1'b0;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, res_at_done, exp_res);
    check({tag, " flags"}, 32'(flags_at_done), 32'(exp_flags));
    check({tag, " done count"}, 32'(n_done), 32'd1);
    check({tag, " busy while active"}, 32'(busy_ok), 32'd1);
    check({tag, " idle after"}, 32'(busy_out), 32'd0);
    check({tag, " result held"}, result_out, exp_res);
  endtask

  initial begin
    int n_done;
    rst_n_in = 1'b0;
    start_in = 1'b1;
    a_in     = 32'h40C0_0000;
    b_in     = 32'h4000_0000;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset result", result_out, 32'h0);
    check("reset busy", 32'(busy_out), 32'd0);
    check("reset done", 32'(done_out), 32'd0);
    check("reset flags", 32'({underflow_out, overflow_out, div_by_zero_out}), 32'd0);
    start_in = 1'b0;
    rst_n_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("start in reset ignored", 32'(busy_out), 32'd0);

    run_op("6/2",       32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 27, 0);
    run_op("1/3",       32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000, 27, 0);
    run_op("-6/2",      32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 3'b000, 27, 0);
    run_op("1/0",       32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b001, 1,  0);
    run_op("-1/0",      32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 3'b001, 1,  0);
    run_op("0/2",       32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 3'b000, 1,  0);
    run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 3'b100, 27, 0);
    run_op("overflow",  32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 3'b010, 27, 0);
    run_op("restart ignored", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 27, 5);

    // Reset at edge k+10 abandons the operation.
    @(negedge clk_in);
    a_in     = 32'h40C0_0000;
    b_in     = 32'h4000_0000;
    start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    repeat (9) @(posedge clk_in);
    #1 rst_n_in = 1'b0;
    @(posedge clk_in);
    #1;
    check("midreset busy", 32'(busy_out), 32'd0);
    check("midreset result", result_out, 32'h0);
    check("midreset done", 32'(done_out), 32'd0);
    rst_n_in = 1'b1;
    n_done   = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk_in);
      #1;
      if (done_out) n_done++;
    end
    check("midreset no done", 32'(n_done), 32'd0);
    run_op("after reset", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000, 27, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
